// File: rtl/dcache_arb_rr.sv
// N-channel arbiter in front of the single dcache tbus port: accepts one request,
// issues it as a one-cycle valid pulse and routes completion back to the granted channel.
// Define DCACHE_ARB_RR_EN for round-robin arbitration; otherwise lowest channel index wins.
module dcache_arb_rr #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int OPT_W  = 2,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH*ADDR_W-1:0] req_index,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  input  logic [NUM_CH*DATA_W-1:0] req_wmask,
  input  logic [NUM_CH*OPT_W-1:0]  req_optype,
  output logic [NUM_CH-1:0]        rsp_done,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     tbus_index_valid,
  input  logic                     tbus_index_ready,
  output logic [ADDR_W-1:0]        tbus_index,
  output logic [DATA_W-1:0]        tbus_write_data,
  output logic [DATA_W-1:0]        tbus_write_mask,
  output logic [OPT_W-1:0]         tbus_operation_type,
  input  logic [DATA_W-1:0]        tbus_read_data,
  input  logic                     tbus_operation_done,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CH_W-1:0] winner;
  logic [CH_W-1:0] grant;
  logic            accept;
  logic            done_now;

  assign accept   = (state == IDLE) && (|req_valid) && tbus_index_ready;
  // Completion is honoured in ISSUE as well as WAIT; done while IDLE is ignored.
  assign done_now = (state != IDLE) && tbus_operation_done;

`ifdef DCACHE_ARB_RR_EN
  logic [CH_W-1:0] rr_ptr;
  logic            found;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    winner = rr_ptr;
    found  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = int'(rr_ptr) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!found && req_valid[c]) begin
        winner = CH_W'(c);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + CH_W'(1);
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_valid[k]) winner = CH_W'(k);
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = done_now ? IDLE : WAIT;
      WAIT:    if (done_now) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready        = accept ? (NUM_CH'(1) << winner) : '0;
    tbus_index_valid = (state == ISSUE);
    busy             = (state != IDLE);
  end

  // Payload is sampled only at acceptance so the tbus outputs hold for the whole transaction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant               <= '0;
      tbus_index          <= '0;
      tbus_write_data     <= '0;
      tbus_write_mask     <= '0;
      tbus_operation_type <= '0;
      rsp_done            <= '0;
      rsp_rdata           <= '0;
    end else begin
      rsp_done <= '0;
      if (accept) begin
        grant               <= winner;
        tbus_index          <= req_index[winner*ADDR_W +: ADDR_W];
        tbus_write_data     <= req_wdata[winner*DATA_W +: DATA_W];
        tbus_write_mask     <= req_wmask[winner*DATA_W +: DATA_W];
        tbus_operation_type <= req_optype[winner*OPT_W +: OPT_W];
      end
      if (done_now) begin
        rsp_done  <= NUM_CH'(1) << grant;
        rsp_rdata <= tbus_read_data;
      end
    end
  end

endmodule

// File: doc/dcache_arb_rr.md
Name: dcache_arb_rr

Overview:
- N-channel successor of the two-channel dcache arbiter. Sits between the load/store requesters (SQ, LSU load pipes, prefetch) and the single dcache tbus port.
- Selects one pending request, latches its payload, and issues it to the dcache as a single-cycle valid pulse.
- Waits for operation_done, then routes done and read data back to the granted channel only.
- All request payloads are registered, so the tbus outputs stay stable for the whole transaction.

Parameters:
- NUM_CH, 3, number of requester channels; channel 0 is the SQ by convention; range 2..8.
- ADDR_W, 64, index width.
- DATA_W, 64, read/write data width; the write mask is also DATA_W wide (bit mask).
- OPT_W, 2, tbus operation type width.
- CH_W, $clog2(NUM_CH), grant index width.

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_CH  per-channel request valid
- req_ready  out  NUM_CH  one-hot, one-cycle accept pulse
- req_index  in  NUM_CH*ADDR_W  packed indices; channel i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CH*DATA_W  packed write data
- req_wmask  in  NUM_CH*DATA_W  packed write masks
- req_optype  in  NUM_CH*OPT_W  packed operation types
- rsp_done  out  NUM_CH  one-hot, one-cycle completion pulse
- rsp_rdata  out  DATA_W  shared read data; valid when any rsp_done bit is high, held until the next done
- tbus_index_valid  out  1  single-cycle issue pulse
- tbus_index_ready  in  1  dcache can accept
- tbus_index  out  ADDR_W  latched index
- tbus_write_data  out  DATA_W  latched write data
- tbus_write_mask  out  DATA_W  latched write mask
- tbus_operation_type  out  OPT_W  latched operation type
- tbus_read_data  in  DATA_W  dcache read data
- tbus_operation_done  in  1  dcache completion
- busy  out  1  high in ISSUE or WAIT

Behaviour:
- Reset values: all outputs 0; state IDLE; grant register 0; round-robin pointer 0.
- States: IDLE, ISSUE, WAIT; 2-bit encoded.
- IDLE:
  - If |req_valid and tbus_index_ready, pick a winner via the arbitration policy.
  - Same edge: latch the winner's index, wdata, wmask and optype into the tbus_* registers; latch the grant index; pulse req_ready[winner] for exactly that cycle (combinational from the IDLE decision). Go to ISSUE.
  - If tbus_index_ready is low, stay in IDLE and assert no req_ready.
- ISSUE:
  - tbus_index_valid=1 for exactly one cycle. Go to WAIT.
  - If tbus_operation_done is already high in this cycle, complete directly (same as WAIT completion) and return to IDLE.
- WAIT:
  - Hold the tbus_* payload stable.
  - On tbus_operation_done: register rsp_rdata<=tbus_read_data and rsp_done<=onehot(grant), visible the next cycle for one cycle. Go to IDLE.
- Latency:
  - Request accepted in cycle T; tbus_index_valid at T+1.
  - Done at cycle D gives rsp_done at D+1.
  - Earliest re-arbitration is cycle D+1, so back-to-back throughput is one request per (dcache latency + 2) cycles.
- Ignored inputs:
  - A requester that drops req_valid before acceptance is simply not selected; no error.
  - tbus_operation_done while in IDLE is ignored and produces no rsp_done.
- Payload stability: req_* payload is sampled only at acceptance; later changes have no effect.
- Priority: the rsp_done pulse and a new acceptance may occur in the same cycle for different channels; allowed.
- Reset mid-transaction: immediately returns to IDLE and clears all outputs; any outstanding dcache operation is abandoned (the dcache is reset on the same net).
- tbus_operation_type passes the requester's optype unmodified.

Optional Feature:
- Macro DCACHE_ARB_RR_EN.
- Defined: round-robin arbitration.
  - The search starts at rr_ptr and wraps modulo NUM_CH.
  - On each acceptance, rr_ptr <= winner+1, wrapping NUM_CH-1 to 0.
- Undefined: fixed priority, lowest index wins (SQ first); rr_ptr is not implemented.

Test Plan:
- Single request: NUM_CH=3; ch1 valid, index 0x1000, optype read; dcache done 3 cycles after valid with rdata 0xDEADBEEF -> req_ready[1] one cycle, tbus_index_valid one pulse with index 0x1000, rsp_done=3'b010 one cycle, rsp_rdata=0xDEADBEEF.
- Contention, fixed priority (macro off): ch0, ch1 and ch2 all held valid for 3 transactions -> grant order 0,0,0 (ch0 re-requests each time); ch1 and ch2 starve.
- Contention, round robin (macro on): all channels continuously valid -> grant order 0,1,2,0; exactly one req_ready bit high per acceptance.
- Back-pressure: tbus_index_ready=0 for 5 cycles with ch2 valid -> no req_ready and no valid pulse; ready high in cycle 6 -> acceptance, and valid at cycle 7.
- Immediate done: done asserted in the ISSUE cycle with write data 0xFF and mask 0xFF -> rsp_done next cycle; FSM back in IDLE; no second valid pulse.
- Reset mid-WAIT: reset_n low during WAIT -> busy=0, all outputs 0; no rsp_done after release; a fresh request then works normally.
